// File: rtl/fht_sequencer.sv
// Address/control sequencer for the 4-bank in-place FHT datapath.
// Walks stages 0..A_BIT, issuing read addresses and delayed write strobes/addresses.
module fht_sequencer #(
   parameter int A_BIT  = 8,
   parameter int WR_LAT = 4,
   parameter int S_BIT  = $clog2(A_BIT + 1)
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iSTART,
   input  logic             iHOLD,
   input  logic             iABORT,
   output logic             oST_ZERO,
   output logic             oST_LAST,
   output logic             o2ND_PART_SUBSEC,
   output logic [A_BIT-1:0] oSECTOR,
   output logic [A_BIT-1:0] oADDR_RD_0,
   output logic [A_BIT-1:0] oADDR_RD_1,
   output logic [A_BIT-1:0] oADDR_RD_2,
   output logic [A_BIT-1:0] oADDR_RD_3,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [A_BIT-1:0] oADDR_WR_BIAS,
   output logic [A_BIT-1:0] oADDR_COEF,
   output logic             oWE_A,
   output logic             oWE_B,
   output logic             oSOURCE_DATA,
   output logic             oSOURCE_CONT,
   output logic             oRDY,
   output logic             oDONE
);

   localparam int WIN   = 2 ** (A_BIT + 1);
   localparam int T_LEN = WIN + WR_LAT + 2;
   localparam int C_BIT = $clog2(T_LEN);

   localparam logic [A_BIT-1:0] ADDR_MAX   = '1;
   localparam logic [A_BIT-1:0] ONE_A      = A_BIT'(1);
   localparam logic [S_BIT-1:0] ONE_S      = S_BIT'(1);
   localparam logic [S_BIT-1:0] STAGE_LAST = S_BIT'(A_BIT);
   localparam logic [C_BIT-1:0] ONE_C      = C_BIT'(1);
   localparam logic [C_BIT-1:0] CYC_LAST   = C_BIT'(T_LEN - 1);
   localparam logic [C_BIT-1:0] CYC_WIN    = C_BIT'(WIN);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           state;
   logic [S_BIT-1:0] stage;
   logic [C_BIT-1:0] cyc;
   logic             ph;
   logic [A_BIT-1:0] addr_rd;
   logic             source_data;
   logic             source_cont;
   logic             done;

   logic [A_BIT-1:0] dl_addr [WR_LAT];
   logic [A_BIT-1:0] dl_mirr [WR_LAT];
   logic             dl_ph   [WR_LAT];
   logic             dl_vld  [WR_LAT];

   logic [A_BIT-1:0] mask;
   logic [A_BIT-1:0] offset;
   logic [A_BIT-1:0] mirror;
   logic [A_BIT-1:0] coef;
   logic [A_BIT-1:0] sector;
   logic             half_sub;
   logic             issue_valid;

   // Sector mask is D-1; stages 0 and 1 both use the full bank depth.
   always_comb begin
      mask        = (stage <= ONE_S) ? ADDR_MAX : (ADDR_MAX >> (stage - ONE_S));
      offset      = addr_rd & mask;
      mirror      = addr_rd;
      coef        = '0;
      sector      = addr_rd >> (A_BIT + 1 - int'(stage));
      half_sub    = |(offset & (mask ^ (mask >> 1)));
      issue_valid = (state == ST_RUN) && (cyc < CYC_WIN);
      if (stage != '0) begin
         mirror = (addr_rd & ~mask) | ((~offset + ONE_A) & mask);
         coef   = offset << (stage - ONE_S);
      end
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state       <= ST_IDLE;
         stage       <= '0;
         cyc         <= '0;
         ph          <= 1'b0;
         addr_rd     <= '0;
         source_data <= 1'b0;
         source_cont <= 1'b1;
         done        <= 1'b0;
         for (int i = 0; i < WR_LAT; i++) begin
            dl_addr[i] <= '0;
            dl_mirr[i] <= '0;
            dl_ph[i]   <= 1'b0;
            dl_vld[i]  <= 1'b0;
         end
      end else begin
         done <= 1'b0;
         if (iABORT) begin
            state       <= ST_IDLE;
            stage       <= '0;
            cyc         <= '0;
            ph          <= 1'b0;
            addr_rd     <= '0;
            source_data <= 1'b0;
            source_cont <= 1'b1;
            for (int i = 0; i < WR_LAT; i++) begin
               dl_addr[i] <= '0;
               dl_mirr[i] <= '0;
               dl_ph[i]   <= 1'b0;
               dl_vld[i]  <= 1'b0;
            end
         end else begin
            source_cont <= (state == ST_IDLE);
            if (!iHOLD) begin
               case (state)
                  ST_IDLE: begin
                     if (iSTART) begin
                        state       <= ST_RUN;
                        stage       <= '0;
                        cyc         <= '0;
                        ph          <= 1'b0;
                        addr_rd     <= '0;
                        source_data <= 1'b0;
                     end
                  end
                  ST_RUN: begin
                     dl_addr[0] <= addr_rd;
                     dl_mirr[0] <= mirror;
                     dl_ph[0]   <= ph;
                     dl_vld[0]  <= issue_valid;
                     for (int i = 1; i < WR_LAT; i++) begin
                        dl_addr[i] <= dl_addr[i-1];
                        dl_mirr[i] <= dl_mirr[i-1];
                        dl_ph[i]   <= dl_ph[i-1];
                        dl_vld[i]  <= dl_vld[i-1];
                     end
                     if (cyc == CYC_LAST) begin
                        source_data <= ~source_data;
                        cyc         <= '0;
                        ph          <= 1'b0;
                        addr_rd     <= '0;
                        if (stage == STAGE_LAST) begin
                           // Flush so write-side addresses read 0 while idle.
                           state <= ST_IDLE;
                           stage <= '0;
                           done  <= 1'b1;
                           for (int i = 0; i < WR_LAT; i++) begin
                              dl_addr[i] <= '0;
                              dl_mirr[i] <= '0;
                              dl_ph[i]   <= 1'b0;
                              dl_vld[i]  <= 1'b0;
                           end
                        end else begin
                           stage <= stage + ONE_S;
                        end
                     end else begin
                        cyc <= cyc + ONE_C;
                        ph  <= ~ph;
                        if (ph && (addr_rd != ADDR_MAX))
                           addr_rd <= addr_rd + ONE_A;
                     end
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign oRDY             = (state == ST_IDLE);
   assign oST_ZERO         = (stage == '0) && !oRDY;
   assign oST_LAST         = (stage == STAGE_LAST) && !oRDY;
   assign o2ND_PART_SUBSEC = half_sub;
   assign oSECTOR          = sector;
   assign oADDR_RD_0       = addr_rd;
   assign oADDR_RD_2       = addr_rd;
   assign oADDR_RD_1       = mirror;
   assign oADDR_RD_3       = mirror;
   assign oADDR_WR         = dl_addr[WR_LAT-1];
   assign oADDR_WR_BIAS    = dl_mirr[WR_LAT-1];
   assign oADDR_COEF       = coef;
   assign oWE_A            = dl_vld[WR_LAT-1] && !dl_ph[WR_LAT-1] && !iHOLD;
   assign oWE_B            = dl_vld[WR_LAT-1] && dl_ph[WR_LAT-1] && !iHOLD;
   assign oSOURCE_DATA     = source_data;
   assign oSOURCE_CONT     = source_cont;
   assign oDONE            = done;

endmodule
